// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg: shared widths, M-extension funct3 encodings and FSM states
package mul_div_unit_pkg;
   localparam int MDU_DATA_WIDTH = 64;
   localparam int MDU_ADDR_WIDTH = 5;
   typedef enum logic [2:0] {
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
   } op_e;
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
endpackage

// File: rtl/mdu_iter_core.sv
// mdu_iter_core: one-bit-per-cycle shift-add multiply / restoring divide on magnitudes
// product ends in {hi, lo}; quotient ends in lo, remainder in hi
module mdu_iter_core #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         step,
   input  logic         div,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] hi,
   output logic [W-1:0] lo,
   output logic         last
);
   localparam int CW = $clog2(W) + 1;
   logic [W-1:0] m;
   logic [CW-1:0] cnt;
   logic div_q;
   logic [W:0] sum, tmp, diff;
   assign sum  = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
   assign tmp  = {hi, lo[W-1]};
   assign diff = tmp - {1'b0, m};
   assign last = cnt == CW'(W - 1);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         hi    <= '0;
         lo    <= '0;
         m     <= '0;
         cnt   <= '0;
         div_q <= 1'b0;
      end else if (load) begin
         hi    <= '0;
         lo    <= a;
         m     <= b;
         cnt   <= '0;
         div_q <= div;
      end else if (step) begin
         cnt <= cnt + CW'(1);
         hi  <= div_q ? (diff[W] ? tmp[W-1:0] : diff[W-1:0]) : sum[W:1];
         lo  <= div_q ? {lo[W-2:0], !diff[W]} : {sum[0], lo[W-1:1]};
      end
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV M-extension multiply/divide unit
// divide-by-zero and signed overflow skip the iteration and finish next cycle
module mul_div_unit
   import mul_div_unit_pkg::*;
#(
   parameter int DATA_WIDTH = MDU_DATA_WIDTH,
   parameter int ADDR_WIDTH = MDU_ADDR_WIDTH
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_start,
   input  logic [2:0]            i_op,
   input  logic [DATA_WIDTH-1:0] i_rs1_data,
   input  logic [DATA_WIDTH-1:0] i_rs2_data,
   input  logic [ADDR_WIDTH-1:0] i_rd,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [DATA_WIDTH-1:0] o_result,
   output logic [ADDR_WIDTH-1:0] o_rd
);
   localparam int W = DATA_WIDTH;
   state_e state, state_nx;
   op_e op_q;
   logic [ADDR_WIDTH-1:0] rd_q, rd_out;
   logic [W-1:0] a_q, res_out, result, hi, lo, a_mag, b_mag, quo, rem;
   logic [2*W-1:0] prod;
   logic a_neg, b_neg, a_neg_q, b_neg_q, dz, ov, dz_q, ov_q, start, last, is_rem;
   assign a_neg = i_rs1_data[W-1] & (i_op[2] ? !i_op[0] : (i_op == OP_MULH || i_op == OP_MULHSU));
   assign b_neg = i_rs2_data[W-1] & (i_op[2] ? !i_op[0] : i_op == OP_MULH);
   assign a_mag = a_neg ? -i_rs1_data : i_rs1_data;
   assign b_mag = b_neg ? -i_rs2_data : i_rs2_data;
   assign dz    = i_op[2] & (i_rs2_data == '0);
   assign ov    = i_op[2] & !i_op[0] & (i_rs1_data == {1'b1, {(W-1){1'b0}}}) & (&i_rs2_data);
   assign start = (state == IDLE) & i_start;
   always_comb
      state_nx = (state == IDLE) ? (i_start ? ((dz | ov) ? DONE : CALC) : IDLE) :
                 (state == CALC) ? (last ? DONE : CALC) : IDLE;
   mdu_iter_core #(.W(W)) u_core (
      .clk(i_clk), .rst_n(i_rst_n), .load(start), .step(state == CALC), .div(i_op[2]),
      .a(a_mag), .b(b_mag), .hi(hi), .lo(lo), .last(last)
   );
   // magnitudes come back unsigned; restore signs before selecting
   always_comb begin
      prod   = (a_neg_q ^ b_neg_q) ? -{hi, lo} : {hi, lo};
      quo    = (a_neg_q ^ b_neg_q) ? -lo : lo;
      rem    = a_neg_q ? -hi : hi;
      is_rem = (op_q == OP_REM) | (op_q == OP_REMU);
      result = dz_q ? (is_rem ? a_q : '1) :
               ov_q ? (is_rem ? '0 : a_q) :
               (op_q == OP_MUL) ? prod[W-1:0] :
               (op_q inside {OP_MULH, OP_MULHSU, OP_MULHU}) ? prod[2*W-1:W] :
               is_rem ? rem : quo;
   end
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         state   <= IDLE;
         op_q    <= OP_MUL;
         rd_q    <= '0;
         rd_out  <= '0;
         a_q     <= '0;
         res_out <= '0;
         a_neg_q <= 1'b0;
         b_neg_q <= 1'b0;
         dz_q    <= 1'b0;
         ov_q    <= 1'b0;
      end else begin
         state <= state_nx;
         if (start) begin
            op_q    <= op_e'(i_op);
            rd_q    <= i_rd;
            a_q     <= i_rs1_data;
            a_neg_q <= a_neg;
            b_neg_q <= b_neg;
            dz_q    <= dz;
            ov_q    <= ov;
         end
         if (state == DONE) begin
            res_out <= result;
            rd_out  <= rd_q;
         end
      end
   assign o_busy   = state != IDLE;
   assign o_done   = state == DONE;
   assign o_result = o_done ? result : res_out;
   assign o_rd     = o_done ? rd_q : rd_out;
endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 64, operand/result width SHALL be set by this parameter.
REQ-002 Parameter ADDR_WIDTH, default 5, destination register index width SHALL be set by this parameter.
REQ-003 i_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 i_rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 i_start  input  1  SHALL request an operation; sampled only in IDLE.
REQ-006 i_op  input  3  SHALL carry RV M-extension funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 i_rs1_data  input  DATA_WIDTH  SHALL carry multiplicand/dividend from register-file read port 1.
REQ-008 i_rs2_data  input  DATA_WIDTH  SHALL carry multiplier/divisor from register-file read port 2.
REQ-009 i_rd  input  ADDR_WIDTH  SHALL carry the destination register index.
REQ-010 o_busy  output  1  SHALL be high while an accepted operation is outstanding; the core stalls the PC on it.
REQ-011 o_done  output  1  SHALL pulse one cycle when o_result is valid; drives the register-file write enable.
REQ-012 o_result  output  DATA_WIDTH  SHALL carry the operation result.
REQ-013 o_rd  output  ADDR_WIDTH  SHALL carry the latched destination index, aligned with o_result.

Function
REQ-014 FSM SHALL have states IDLE, CALC, DONE.
REQ-015 IDLE with i_start=1 SHALL latch i_op, i_rd, both operands and go to CALC (or DONE on fast path); i_start outside IDLE SHALL be ignored.
REQ-016 CALC SHALL run exactly DATA_WIDTH iterations (one bit/cycle: shift-add multiply, restoring divide on operand magnitudes), then go to DONE.
REQ-017 DONE SHALL last one cycle with o_done=1, then return to IDLE.
REQ-018 Normal latency: start sampled at edge k -> o_done high in cycle k+DATA_WIDTH+1 (65 for default).
REQ-019 o_busy SHALL be high in CALC and DONE, low in IDLE.
REQ-020 MUL SHALL return low DATA_WIDTH bits; MULH/MULHSU/MULHU high DATA_WIDTH bits of the 2*DATA_WIDTH product (signed x signed, signed x unsigned, unsigned x unsigned).
REQ-021 Signed ops SHALL negate the magnitude result when operand signs differ; signed remainder SHALL take the dividend's sign.
REQ-022 Divide by zero SHALL take the fast path (DONE at k+1): quotient all ones, remainder = dividend.
REQ-023 Signed overflow (DIV/REM, dividend = most-negative, divisor = -1) SHALL take the fast path: quotient = dividend, remainder = 0.
REQ-024 o_result and o_rd SHALL hold their last values until the next DONE.
REQ-025 i_rd=0 SHALL still complete normally; discarding the x0 write is the register file's responsibility.

Reset
REQ-026 i_rst_n low SHALL immediately force IDLE and clear o_busy, o_done, o_result, o_rd and all datapath registers to 0, including mid-CALC; no o_done for an aborted operation.
REQ-027 First i_start honoured SHALL be the first rising edge after i_rst_n deasserts.

Structure
REQ-028 Shared package SHALL hold the i_op funct3 enum and the FSM state enum; DATA_WIDTH/ADDR_WIDTH defaults shall match the register file.
REQ-029 Sign handling and result selection SHALL be combinational; one natural sub-module, mdu_iter_core, SHALL hold the shift-add/restoring-divide iteration datapath.

Verification
REQ-030 MUL 7 x -3 -> o_done at k+65, o_result=-21 (0xFFFF_FFFF_FFFF_FFEB), o_rd echoed.
REQ-031 MULHU 0xFFFF_FFFF_FFFF_FFFF x 2 -> o_result=1; MULH same operands -> o_result=0xFFFF_FFFF_FFFF_FFFF.
REQ-032 DIV -7 / 2 -> -3; REM -7 / 2 -> -1; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2, each at k+65.
REQ-033 DIVU 5 / 0 -> o_done at k+1, o_result=0xFFFF_FFFF_FFFF_FFFF; REM 5 / 0 -> 5; DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000 at k+1.
REQ-034 Second i_start during CALC -> ignored, single o_done; back-to-back start in IDLE the cycle after DONE -> accepted.
REQ-035 i_rst_n low at cycle k+30 of a DIV -> outputs 0 at once, no o_done; new MUL after release completes correctly.
